issue_buffer: RTL
=================

ISSUE_BUFFER -- requirements
Module: issue_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, at least 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Flush  input  1  discard all entries; wrong-path squash.
REQ-005 SHALL have port Stall  input  1  decode stalled; no entries leave.
REQ-006 SHALL have ports InstrFA, InstrFB  input  32 each  fetched instructions; A is older.
REQ-007 SHALL have ports PCFA, PCFB  input  32 each  PCs of InstrFA, InstrFB.
REQ-008 SHALL have ports ValidFA, ValidFB  input  1 each  slot holds an instruction; ValidFB without ValidFA is illegal.
REQ-009 SHALL have port Ready  output  1  buffer can take two entries this cycle.
REQ-010 SHALL have ports InstrDA, InstrDB  output  32 each  instructions presented to decode lanes A/B.
REQ-011 SHALL have ports PCDA, PCDB  output  32 each  PCs of InstrDA, InstrDB.
REQ-012 SHALL have ports ValidDA, ValidDB  output  1 each  lane issues this cycle.

Function
REQ-013 SHALL hold a circular buffer of DEPTH entries {Instr, PC}, with head, tail, and count in 0..DEPTH.
REQ-014 SHALL drive Ready = (count <= DEPTH-2), combinationally from registered count.
REQ-015 SHALL push only when Ready and not Flush: 0, 1, or 2 entries per ValidFA/ValidFB, A at tail, B at tail+1, modulo DEPTH.
REQ-016 SHALL silently drop writes when Ready=0; fetch holds its PC.
REQ-017 SHALL present the head entry on lane A and head+1 on lane B combinationally; no entry becomes visible in the cycle it is written (write-to-issue latency 1 cycle).
REQ-018 SHALL drive ValidDA = (count >= 1) and not Stall.
REQ-019 SHALL drive ValidDB = ValidDA, count >= 2, and pair-legal.
REQ-020 SHALL define pair-legal as all of: A not branch/jump (opcode 2,3,4,5 or funct 8/9 with opcode 0); not both A and B load/store (opcode 0x23/0x2B); B's rs and rt differ from A's destination.
REQ-021 SHALL take A's destination as: rd if opcode 0; 31 if opcode 3; rt for other register-writing opcodes. Register 0 and non-writing instructions (sw, branches, j) impose no dependency.
REQ-022 SHALL pop ValidDA+ValidDB entries at the clock edge; head advances modulo DEPTH.
REQ-023 SHALL apply push and pop in the same cycle: count_next = count + pushed - popped.
REQ-024 SHALL give Flush priority over everything: next head = tail = count = 0, the cycle's push ignored, ValidDA/ValidDB forced 0 combinationally.
REQ-025 SHALL drive zero on InstrD*/PCD* for any lane whose entry is empty.

Reset
REQ-026 SHALL, on reset assertion and without waiting for clk, set head = tail = count = 0, giving Ready=1, ValidDA=ValidDB=0, and InstrD*/PCD* = 0.
REQ-027 SHALL discard in-flight pushes and pops on reset mid-operation; the first edge after deassertion may accept a push.
REQ-028 SHALL not reset entry storage; empty lanes are masked per REQ-025.

Verification
REQ-029 SHALL show pairing: push add $1,$2,$3 and sub $4,$5,$6 at PC 0x0/0x4 -> next cycle ValidDA=ValidDB=1, PCDA=0x0, PCDB=0x4; following cycle count=0.
REQ-030 SHALL show a RAW split: push lw $1,0($2) then add $3,$1,$4 -> cycle 1 ValidDA=1, ValidDB=0; cycle 2 add issues on lane A.
REQ-031 SHALL show full and wrap: with DEPTH=8 push 2 per cycle under Stall=1 for 4 cycles -> count=8, Ready=0, the fifth push dropped; release Stall -> entries issue in PC order across the index wrap 7->0.
REQ-032 SHALL show flush precedence: count=5 with Flush=1 and a simultaneous push -> next cycle count=0, Ready=1, ValidDA=0.
REQ-033 SHALL show async reset: assert reset mid-cycle with count=3 -> ValidDA drops to 0 before the next clk edge.
REQ-034 SHALL show the branch rule: push beq then addi -> beq issues alone on lane A, addi on lane A the following cycle.

Source files
------------

// File: rtl/issue_buffer.sv
// Dual-issue instruction buffer between fetch and decode: a circular queue of
// {Instr, PC} entries that takes up to two fetched instructions and issues up to two per cycle.
module issue_buffer #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Flush,
   input  logic        Stall,
   input  logic [31:0] InstrFA,
   input  logic [31:0] InstrFB,
   input  logic [31:0] PCFA,
   input  logic [31:0] PCFB,
   input  logic        ValidFA,
   input  logic        ValidFB,
   output logic        Ready,
   output logic [31:0] InstrDA,
   output logic [31:0] InstrDB,
   output logic [31:0] PCDA,
   output logic [31:0] PCDB,
   output logic        ValidDA,
   output logic        ValidDB
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   READY_MAX = (AW + 1)'(DEPTH - 2);
   localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_TWO   = (AW + 1)'(2);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [31:0] instr_mem [DEPTH];
   logic [31:0] pc_mem    [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;

   logic [AW-1:0] head_b;
   logic [AW-1:0] tail_b;
   logic          lane_a_full;
   logic          lane_b_full;
   logic          accept;
   logic          push_a;
   logic          push_b;
   logic [AW:0]   push_cnt;
   logic [AW:0]   pop_cnt;

   logic [5:0]    op_a;
   logic [5:0]    funct_a;
   logic [4:0]    rt_a;
   logic [4:0]    rd_a;
   logic [5:0]    op_b;
   logic [4:0]    rs_b;
   logic [4:0]    rt_b;
   logic          a_branch;
   logic          a_mem;
   logic          b_mem;
   logic [4:0]    a_dest;
   logic          raw_hazard;
   logic          pair_legal;

   assign head_b      = head + PTR_ONE;
   assign tail_b      = tail + PTR_ONE;
   assign lane_a_full = (count >= CNT_ONE);
   assign lane_b_full = (count >= CNT_TWO);

   assign Ready = (count <= READY_MAX);

   // Lanes show the two oldest entries; a lane with no entry behind it reads as zero.
   assign InstrDA = lane_a_full ? instr_mem[head]   : 32'd0;
   assign PCDA    = lane_a_full ? pc_mem[head]      : 32'd0;
   assign InstrDB = lane_b_full ? instr_mem[head_b] : 32'd0;
   assign PCDB    = lane_b_full ? pc_mem[head_b]    : 32'd0;

   assign op_a    = InstrDA[31:26];
   assign funct_a = InstrDA[5:0];
   assign rt_a    = InstrDA[20:16];
   assign rd_a    = InstrDA[15:11];
   assign op_b    = InstrDB[31:26];
   assign rs_b    = InstrDB[25:21];
   assign rt_b    = InstrDB[20:16];

   // Pairing check: lane B may only issue alongside A when A does not redirect
   // control flow, the two do not both need the memory port, and B reads nothing A writes.
   always_comb begin
      a_branch = (op_a inside {6'd2, 6'd3, 6'd4, 6'd5}) ||
                 ((op_a == 6'd0) && ((funct_a == 6'd8) || (funct_a == 6'd9)));
      a_mem    = (op_a == 6'h23) || (op_a == 6'h2B);
      b_mem    = (op_b == 6'h23) || (op_b == 6'h2B);
      a_dest   = 5'd0;
      case (op_a)
         6'h00:                    a_dest = rd_a;
         6'h03:                    a_dest = 5'd31;
         6'h01, 6'h02, 6'h04,
         6'h05, 6'h06, 6'h07,
         6'h28, 6'h29, 6'h2B:      a_dest = 5'd0;
         default:                  a_dest = rt_a;
      endcase
      raw_hazard = (a_dest != 5'd0) && ((rs_b == a_dest) || (rt_b == a_dest));
      pair_legal = !a_branch && !(a_mem && b_mem) && !raw_hazard;
   end

   assign ValidDA = lane_a_full && !Stall && !Flush;
   assign ValidDB = ValidDA && lane_b_full && pair_legal;

   // A lone ValidFB is treated as nothing to push so the queue never holds a gap.
   assign accept = Ready && !Flush;
   assign push_a = accept && ValidFA;
   assign push_b = accept && ValidFA && ValidFB;

   always_comb begin
      push_cnt = '0;
      pop_cnt  = '0;
      if (push_b) begin
         push_cnt = CNT_TWO;
      end else if (push_a) begin
         push_cnt = CNT_ONE;
      end
      if (ValidDB) begin
         pop_cnt = CNT_TWO;
      end else if (ValidDA) begin
         pop_cnt = CNT_ONE;
      end
   end

   // Pointer and occupancy state; Flush wipes the queue and overrides any push or pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (Flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + pop_cnt[AW-1:0];
         tail  <= tail + push_cnt[AW-1:0];
         count <= count + push_cnt - pop_cnt;
      end
   end

   // Entry storage is left unreset; stale contents are hidden by the occupancy masks.
   always_ff @(posedge clk) begin
      if (push_a) begin
         instr_mem[tail] <= InstrFA;
         pc_mem[tail]    <= PCFA;
      end
      if (push_b) begin
         instr_mem[tail_b] <= InstrFB;
         pc_mem[tail_b]    <= PCFB;
      end
   end

endmodule
